// File: rtl/multi_cycle_control.sv
// rtl/multi_cycle_control.sv - multi-cycle CPU control FSM with run/step gating and retired-instruction counter
module multi_cycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  OP,
  input  logic        Zero,
  input  logic        Run,
  input  logic        Step,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        ALUSrc,
  output logic        Trap,
  output logic [2:0]  ALUOp,
  output logic [2:0]  State,
  output logic [15:0] InstrCount
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC_R = 3'd2,
    S_EXEC_I = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  r_opcode;
  logic [15:0] r_instr_count;
  logic        w_go;
  logic        w_is_r;
  logic        w_is_ori;
  logic        w_is_beq;
  logic        w_is_bne;
  logic        w_retire;
  logic [2:0]  w_imm_aluop;

  assign w_go        = Run | Step;
  assign w_is_r      = (r_opcode == OP_RTYPE);
  assign w_is_ori    = (r_opcode == OP_ORI);
  assign w_is_beq    = (r_opcode == OP_BEQ);
  assign w_is_bne    = (r_opcode == OP_BNE);
  assign w_imm_aluop = w_is_ori ? 3'b101 : 3'b100;
  assign w_retire    = (r_state == S_WB) || (r_state == S_BRANCH);

  assign State      = r_state;
  assign InstrCount = r_instr_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_FETCH;
      r_opcode      <= 6'h00;
      r_instr_count <= 16'h0000;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_opcode <= OP;
      end
      if (w_retire) begin
        r_instr_count <= r_instr_count + 16'd1;
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    ALUSrc   = 1'b0;
    Trap     = 1'b0;
    ALUOp    = 3'b000;
    case (r_state)
      S_FETCH: begin
        if (w_go) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        // The opcode register is loaded on this edge, so route on the live OP.
        case (OP)
          OP_RTYPE:        w_next = S_EXEC_R;
          OP_ADDI, OP_ORI: w_next = S_EXEC_I;
          OP_BEQ, OP_BNE:  w_next = S_BRANCH;
          default:         w_next = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        ALUOp  = 3'b111;
        w_next = S_WB;
      end
      S_EXEC_I: begin
        ALUSrc = 1'b1;
        ALUOp  = w_imm_aluop;
        w_next = S_WB;
      end
      S_WB: begin
        RegWrite = 1'b1;
        if (w_is_r) begin
          ALUOp  = 3'b111;
          RegDst = 1'b1;
        end else begin
          ALUSrc = 1'b1;
          ALUOp  = w_imm_aluop;
        end
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUOp   = 3'b001;
        PCSrc   = 1'b1;
        PCWrite = (w_is_beq & Zero) | (w_is_bne & ~Zero);
        w_next  = S_FETCH;
      end
      S_TRAP: begin
        Trap   = 1'b1;
        w_next = S_TRAP;
      end
      default: w_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// tb/tb_multi_cycle_control.sv - directed self-checking bench for multi_cycle_control
module tb_multi_cycle_control;

  logic        clk;
  logic        reset;
  logic [5:0]  OP;
  logic        Zero;
  logic        Run;
  logic        Step;
  logic        IRWrite;
  logic        PCWrite;
  logic        PCSrc;
  logic        RegWrite;
  logic        RegDst;
  logic        ALUSrc;
  logic        Trap;
  logic [2:0]  ALUOp;
  logic [2:0]  State;
  logic [15:0] InstrCount;

  int n_cmp;
  int n_bad;

  multi_cycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .OP         (OP),
    .Zero       (Zero),
    .Run        (Run),
    .Step       (Step),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .PCSrc      (PCSrc),
    .RegWrite   (RegWrite),
    .RegDst     (RegDst),
    .ALUSrc     (ALUSrc),
    .Trap       (Trap),
    .ALUOp      (ALUOp),
    .State      (State),
    .InstrCount (InstrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    OP    = 6'h00;
    Zero  = 1'b0;
    Run   = 1'b0;
    Step  = 1'b0;
    tick();
    tick();
    chk("rst_state", State, 0);
    chk("rst_count", InstrCount, 0);
    chk("rst_irwrite", IRWrite, 0);
    chk("rst_pcwrite", PCWrite, 0);
    chk("rst_trap", Trap, 0);
    chk("rst_aluop", ALUOp, 0);
    reset = 1'b1;
    tick();
    #1;
    chk("idle_state", State, 0);
    chk("idle_irwrite", IRWrite, 0);
    chk("idle_pcwrite", PCWrite, 0);

    // Free-running R-type, Run dropped during WB
    Run = 1'b1; OP = 6'h00; #1;
    chk("r_fetch_irwrite", IRWrite, 1);
    chk("r_fetch_pcwrite", PCWrite, 1);
    chk("r_fetch_pcsrc", PCSrc, 0);
    tick();
    chk("r_decode_state", State, 1);
    chk("r_decode_irwrite", IRWrite, 0);
    chk("r_decode_regwrite", RegWrite, 0);
    tick();
    chk("r_exec_state", State, 2);
    chk("r_exec_aluop", ALUOp, 3'b111);
    chk("r_exec_alusrc", ALUSrc, 0);
    chk("r_exec_regwrite", RegWrite, 0);
    tick();
    chk("r_wb_state", State, 4);
    chk("r_wb_regwrite", RegWrite, 1);
    chk("r_wb_regdst", RegDst, 1);
    chk("r_wb_aluop", ALUOp, 3'b111);
    Run = 1'b0; #1;
    tick();
    chk("r_done_state", State, 0);
    chk("r_done_count", InstrCount, 1);
    chk("r_halt_irwrite", IRWrite, 0);
    tick();
    chk("r_halt_state", State, 0);

    // beq with Zero=1 taken; Zero toggled in BRANCH to exercise the combinational path
    Run = 1'b1; OP = 6'h04; Zero = 1'b1; #1;
    tick();
    tick();
    chk("beq_state", State, 5);
    chk("beq_pcwrite", PCWrite, 1);
    chk("beq_pcsrc", PCSrc, 1);
    chk("beq_aluop", ALUOp, 3'b001);
    Zero = 1'b0; #1;
    chk("beq_nz_pcwrite", PCWrite, 0);
    Zero = 1'b1; Run = 1'b0; #1;
    tick();
    chk("beq_done_state", State, 0);
    chk("beq_count", InstrCount, 2);

    // bne with Zero=1 not taken, still retires
    Run = 1'b1; OP = 6'h05; #1;
    tick();
    tick();
    chk("bne_state", State, 5);
    chk("bne_pcwrite", PCWrite, 0);
    chk("bne_pcsrc", PCSrc, 1);
    Run = 1'b0; #1;
    tick();
    chk("bne_done_state", State, 0);
    chk("bne_count", InstrCount, 3);

    // Single-step addi with a one-cycle Step pulse
    Step = 1'b1; OP = 6'h08; #1;
    chk("step_fetch_irwrite", IRWrite, 1);
    tick();
    Step = 1'b0;
    chk("step_decode_state", State, 1);
    tick();
    chk("step_exec_state", State, 3);
    chk("step_exec_aluop", ALUOp, 3'b100);
    chk("step_exec_alusrc", ALUSrc, 1);
    tick();
    chk("step_wb_state", State, 4);
    chk("step_wb_aluop", ALUOp, 3'b100);
    chk("step_wb_alusrc", ALUSrc, 1);
    chk("step_wb_regwrite", RegWrite, 1);
    chk("step_wb_regdst", RegDst, 0);
    tick();
    chk("step_done_state", State, 0);
    chk("step_count", InstrCount, 4);
    tick();
    chk("step_halt_state", State, 0);
    chk("step_halt_irwrite", IRWrite, 0);

    // ori with Step held high across the whole pass
    Step = 1'b1; OP = 6'h0D; #1;
    tick();
    tick();
    chk("ori_exec_state", State, 3);
    chk("ori_exec_aluop", ALUOp, 3'b101);
    tick();
    chk("ori_wb_aluop", ALUOp, 3'b101);
    tick();
    chk("ori_done_state", State, 0);
    chk("ori_count", InstrCount, 5);
    chk("ori_held_irwrite", IRWrite, 1);
    Step = 1'b0; #1;
    tick();
    chk("ori_halt_state", State, 0);

    // Counter wrap from 0xFFFF
    force dut.r_instr_count = 16'hFFFF;
    #1;
    release dut.r_instr_count;
    #1;
    chk("wrap_preload", InstrCount, 16'hFFFF);
    Run = 1'b1; OP = 6'h00; #1;
    tick();
    tick();
    tick();
    Run = 1'b0; #1;
    tick();
    chk("wrap_state", State, 0);
    chk("wrap_count", InstrCount, 16'h0000);

    // Asynchronous reset while in EXEC_I
    Run = 1'b1; OP = 6'h08; #1;
    tick();
    tick();
    tick();
    tick();
    tick();
    chk("arst_pre_count", InstrCount, 1);
    tick();
    chk("arst_pre_state", State, 3);
    #1 reset = 1'b0;
    #1;
    chk("arst_state", State, 0);
    chk("arst_count", InstrCount, 0);
    chk("arst_aluop", ALUOp, 0);
    chk("arst_alusrc", ALUSrc, 0);
    Run = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("arst_after_state", State, 0);

    // Illegal opcode traps and ignores Run/Step until reset
    Run = 1'b1; Step = 1'b1; OP = 6'h23; #1;
    tick();
    tick();
    chk("trap_state", State, 6);
    chk("trap_flag", Trap, 1);
    chk("trap_irwrite", IRWrite, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("trap_hold_state", State, 6);
      chk("trap_hold_flag", Trap, 1);
      chk("trap_hold_pcwrite", PCWrite, 0);
    end
    chk("trap_count", InstrCount, 0);
    reset = 1'b0; #1;
    chk("trap_rst_state", State, 0);
    chk("trap_rst_flag", Trap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port OP, input, 6 bits: opcode, Instruction[31:26] from the instruction register.
REQ-004 SHALL have port Zero, input, 1 bit: ALU zero flag.
REQ-005 SHALL have port Run, input, 1 bit: 1 = free-run; 0 = halt at FETCH.
REQ-006 SHALL have port Step, input, 1 bit: single-step request, sampled only in FETCH while Run=0.
REQ-007 SHALL have outputs IRWrite, PCWrite, PCSrc, RegWrite, RegDst, ALUSrc, Trap, 1 bit each: datapath strobes/selects.
REQ-008 SHALL have output ALUOp, 3 bits: code to ALU control.
REQ-009 SHALL have output State, 3 bits: current FSM state code.
REQ-010 SHALL have output InstrCount, 16 bits: retired-instruction counter.

Function
REQ-011 SHALL implement the states FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, WB=4, BRANCH=5, TRAP=6; State SHALL equal the registered state code.
REQ-012 SHALL, in FETCH with go=(Run|Step), assert IRWrite=1 and PCWrite=1 with PCSrc=0 (PC<=PC+4), then go to DECODE.
REQ-013 SHALL, in FETCH with go=0, assert all strobes 0 and remain in FETCH.
REQ-014 SHALL, in DECODE, register OP into an internal opcode register, assert no strobes, and select the next state: 0x00->EXEC_R; 0x08 (addi) or 0x0D (ori)->EXEC_I; 0x04 (beq) or 0x05 (bne)->BRANCH; any other opcode->TRAP.
REQ-015 SHALL, in EXEC_R, drive ALUSrc=0 and ALUOp=3'b111, then go to WB.
REQ-016 SHALL, in EXEC_I, drive ALUSrc=1 and ALUOp=3'b100 (addi) or 3'b101 (ori), then go to WB.
REQ-017 SHALL, in WB, hold the ALUSrc/ALUOp values of the preceding EXEC state, assert RegWrite=1, drive RegDst=1 for R-type and 0 for I-type, increment InstrCount, then go to FETCH.
REQ-018 SHALL, in BRANCH, drive ALUSrc=0, ALUOp=3'b001 and PCSrc=1, then go to FETCH.
REQ-019 SHALL, in BRANCH, drive PCWrite=(beq & Zero)|(bne & ~Zero) combinationally from Zero.
REQ-020 SHALL, in BRANCH, increment InstrCount whether or not the branch is taken.
REQ-021 SHALL, in TRAP, assert Trap=1 with all other strobes 0 and remain in TRAP until reset; Run and Step SHALL have no effect there.
REQ-022 SHALL take 4 cycles per R/I instruction and 3 cycles per branch, counted from the FETCH cycle with go=1.
REQ-023 SHALL wrap InstrCount from 0xFFFF to 0x0000.
REQ-024 SHALL ignore Step while Run=1.
REQ-025 SHALL, with Run=0, execute exactly one instruction per FETCH cycle in which Step=1; Step held high SHALL execute one instruction per pass through FETCH.
REQ-026 SHALL, when Run is deasserted mid-instruction, complete the current instruction and halt at the next FETCH.
REQ-027 SHALL drive ALUOp=3'b000, ALUSrc=0 and RegDst=0 in every state not listed in REQ-015 to REQ-018.
REQ-028 SHALL produce strobe outputs as decoded, glitch-free functions of State, the internal opcode register, Run, Step and Zero only.

Reset
REQ-029 SHALL, on reset=0 at any time including mid-instruction, immediately force State=FETCH, InstrCount=0, internal opcode=0 and all strobes, Trap and ALUOp to 0.
REQ-030 SHALL, after reset release, hold all strobes 0 until the first FETCH cycle with go=1.

Verification
REQ-031 SHALL verify free-run: Run=1 with OP=0x00 -> State sequence 0,1,2,4,0; RegWrite=1 and RegDst=1 only in WB; InstrCount=1 after 4 cycles.
REQ-032 SHALL verify branches: beq with Zero=1 -> PCWrite=1 and PCSrc=1 in BRANCH; bne with Zero=1 -> PCWrite=0; InstrCount increments in both cases; each takes 3 cycles.
REQ-033 SHALL verify single-step: Run=0, Step=0 -> State stays 0 with strobes 0; one-cycle Step pulse with addi -> exactly one instruction (0,1,3,4,0) with ALUOp=3'b100, then halt.
REQ-034 SHALL verify trap: OP=0x23 in DECODE -> State=6 and Trap=1, held for at least 10 cycles with Run=1 and Step=1; reset=0 -> State=0 and Trap=0.
REQ-035 SHALL verify counter wrap: InstrCount at 0xFFFF plus one retired instruction -> 0x0000.
REQ-036 SHALL verify asynchronous reset: reset=0 asserted in EXEC_I between clock edges -> State=0 and InstrCount=0 before the next edge.
